// File: rtl/sbentsrc_ht_if.sv
// Handshake and control bundle for the S-box entropy source.
// master: the entropy source itself (drives the conditioned word and status).
// slave:  the consumer / controller side (drives enable, test injection, ready).
interface sbentsrc_ht_if #(
   parameter int NCH       = 4,
   parameter int OUT_WIDTH = 32
);
   logic                 i_en;
   logic                 i_test_mode;
   logic [4*NCH-1:0]     i_test_raw;
   logic [OUT_WIDTH-1:0] o_rnd;
   logic                 o_valid;
   logic                 i_ready;
   logic                 o_drop;
   logic                 o_alarm;
   logic [NCH-1:0]       o_alarm_ch;
   logic [1:0]           o_state;

   modport master (
      input  i_en, i_test_mode, i_test_raw, i_ready,
      output o_rnd, o_valid, o_drop, o_alarm, o_alarm_ch, o_state
   );

   modport slave (
      output i_en, i_test_mode, i_test_raw, i_ready,
      input  o_rnd, o_valid, o_drop, o_alarm, o_alarm_ch, o_state
   );
endinterface

// File: rtl/sbentsrc_ht.sv
// Multi-channel S-box entropy source with repetition-count health test,
// XOR decimation, word packing and a valid/ready output that never stalls
// the sampling path (words that cannot be delivered are dropped and flagged).
module sbentsrc_ht #(
   parameter int NCH         = 4,
   parameter int OUT_WIDTH   = 32,
   parameter int DECIM       = 8,
   parameter int WARMUP      = 64,
   parameter int STUCK_LIMIT = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   sbentsrc_ht_if.master bus
);
   localparam int SW     = 4 * NCH;
   localparam int NCHUNK = OUT_WIDTH / SW;
   localparam int DW     = (DECIM > 1)  ? $clog2(DECIM)  : 1;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int WW     = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int RW     = $clog2(STUCK_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_ALARM  = 2'd3
   } state_t;

   state_t                  state_q, state_n;
   logic                    active, run;

   logic [SW-1:0]           ring_q, ring_n, ring_smp;
   logic [SW-1:0]           s_q, prev_q;

   logic [WW-1:0]           warm_q;
   logic [NCH-1:0][RW-1:0]  rep_q;
   logic [NCH-1:0]          eq, fail;

   logic [SW-1:0]           acc_q;
   logic [DW-1:0]           dec_q;
   logic [CW-1:0]           chunk_q;
   logic [OUT_WIDTH-1:0]    word_q, word_next;
   logic                    dec_last, chunk_last, word_done;

   logic [OUT_WIDTH-1:0]    rnd_q;
   logic                    valid_q, drop_q, alarm_q;
   logic [NCH-1:0]          alarm_ch_q;

   // PRESENT 4-bit S-box: the substitution each ring stage implements.
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   // Ring next value and out^check sample per channel (clocked stand-in for the self-timed core).
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      ring_n   = '0;
      ring_smp = '0;
      for (int c = 0; c < NCH; c++) begin
         ring_n[4*c +: 4]   = sbox(ring_q[4*c +: 4] ^ 4'(c));
         ring_smp[4*c +: 4] = ring_q[4*c +: 4] ^ ring_n[4*c +: 4];
      end
   end

   // Ring loop runs only while enabled; disabled or in reset it is forced to zero.
   always_ff @(posedge i_clk or posedge i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_reset)        ring_q <= '0;
      else if (!bus.i_en) ring_q <= '0;
      else                ring_q <= ring_n;
   end

   // Sample register and its one-cycle history for the repetition test.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         s_q    <= '0;
         prev_q <= '0;
      end else begin
         s_q    <= bus.i_test_mode ? bus.i_test_raw : ring_smp;
         prev_q <= s_q;
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_n;
   end

   // FSM next-state: disable wins, then health failure, then warm-up expiry.
   always_comb begin
      state_n = state_q;
      if (!bus.i_en) begin
         state_n = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_n = ST_WARMUP;
            ST_WARMUP: begin
               if (|fail)                            state_n = ST_ALARM;
               else if (warm_q == WW'(WARMUP - 1))   state_n = ST_RUN;
            end
            ST_RUN:    if (|fail) state_n = ST_ALARM;
            default:   state_n = ST_ALARM;
         endcase
      end
   end

   // FSM outputs: phase qualifiers for the datapath and the visible state code.
   always_comb begin
      active      = (state_q == ST_WARMUP) || (state_q == ST_RUN);
      run         = (state_q == ST_RUN);
      bus.o_state = state_q;
   end

   // Repetition detection and packing arithmetic for the current sample.
   always_comb begin
      eq   = '0;
      fail = '0;
      for (int c = 0; c < NCH; c++) begin
         eq[c]   = (s_q[4*c +: 4] == prev_q[4*c +: 4]);
         // rep_q counts equal pairs, so STUCK_LIMIT identical nibbles means STUCK_LIMIT-1 pairs.
         fail[c] = active && eq[c] && (rep_q[c] == RW'(STUCK_LIMIT - 2));
      end
      dec_last   = (dec_q == DW'(DECIM - 1));
      chunk_last = (chunk_q == CW'(NCHUNK - 1));
      word_done  = dec_last && chunk_last;
      word_next  = (word_q << SW) | OUT_WIDTH'(acc_q ^ s_q);
   end

   // Health counters, conditioning pipeline and output handshake.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         warm_q     <= '0;
         rep_q      <= '0;
         acc_q      <= '0;
         dec_q      <= '0;
         chunk_q    <= '0;
         word_q     <= '0;
         rnd_q      <= '0;
         valid_q    <= 1'b0;
         drop_q     <= 1'b0;
         alarm_q    <= 1'b0;
         alarm_ch_q <= '0;
      end else begin
         drop_q <= 1'b0;
         if (state_n == ST_IDLE) begin
            // Entering or staying in IDLE wipes everything except the last delivered word.
            warm_q     <= '0;
            rep_q      <= '0;
            acc_q      <= '0;
            dec_q      <= '0;
            chunk_q    <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            alarm_q    <= 1'b0;
            alarm_ch_q <= '0;
         end else begin
            if (state_q == ST_WARMUP) warm_q <= warm_q + WW'(1);

            for (int c = 0; c < NCH; c++) begin
               rep_q[c] <= (active && eq[c]) ? rep_q[c] + RW'(1) : '0;
            end

            if (|fail) begin
               alarm_q    <= 1'b1;
               alarm_ch_q <= alarm_ch_q | fail;
            end

            if (state_n == ST_ALARM) begin
               // Alarm discards the in-flight word and withdraws any pending one.
               valid_q <= 1'b0;
               acc_q   <= '0;
               dec_q   <= '0;
               chunk_q <= '0;
               word_q  <= '0;
            end else if (run) begin
               if (dec_last) begin
                  acc_q   <= '0;
                  dec_q   <= '0;
                  word_q  <= word_next;
                  chunk_q <= chunk_last ? '0 : chunk_q + CW'(1);
               end else begin
                  acc_q <= acc_q ^ s_q;
                  dec_q <= dec_q + DW'(1);
               end

               if (word_done) begin
                  // A new word may replace one that is being transferred this cycle.
                  if (!valid_q || bus.i_ready) begin
                     rnd_q   <= word_next;
                     valid_q <= 1'b1;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end else if (valid_q && bus.i_ready) begin
                  valid_q <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.o_rnd      = rnd_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_drop     = drop_q;
   assign bus.o_alarm    = alarm_q;
   assign bus.o_alarm_ch = alarm_ch_q;
endmodule

// File: tb/tb_sbentsrc_ht.sv
// Directed bench for sbentsrc_ht in test mode (NCH=1, OUT_WIDTH=8, DECIM=2,
// WARMUP=4, STUCK_LIMIT=16). Inputs change 1 ns after a rising edge and
// outputs are checked at that same point, well clear of the next edge.
module tb_sbentsrc_ht;
   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   sbentsrc_ht_if #(.NCH(1), .OUT_WIDTH(8)) bus ();

   sbentsrc_ht #(
      .NCH(1), .OUT_WIDTH(8), .DECIM(2), .WARMUP(4), .STUCK_LIMIT(16)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [3:0] v);
      bus.i_test_raw = v;
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_state"}, 32'(bus.o_state), 32'd0);
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
      chk({tag, "_rnd"},   32'(bus.o_rnd),   32'd0);
      chk({tag, "_alarm"}, 32'(bus.o_alarm), 32'd0);
      chk({tag, "_ch"},    32'(bus.o_alarm_ch), 32'd0);
      chk({tag, "_drop"},  32'(bus.o_drop),  32'd0);
   endtask

   // Four WARMUP cycles with incrementing raw data, then the edge into RUN
   // which also loads 'first' into the sample register.
   task automatic warmup(input logic [3:0] first);
      for (int i = 0; i < 4; i++) begin
         bus.i_test_raw = 4'(10 + i);
         tick();
         chk("warmup_state", 32'(bus.o_state), 32'd1);
         chk("warmup_valid", 32'(bus.o_valid), 32'd0);
      end
      bus.i_test_raw = first;
      tick();
      chk("run_entry_state", 32'(bus.o_state), 32'd2);
      chk("run_entry_valid", 32'(bus.o_valid), 32'd0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.i_en        = 1'b0;
      bus.i_test_mode = 1'b1;
      bus.i_test_raw  = 4'h0;
      bus.i_ready     = 1'b0;

      #3;
      chk_zero("reset");
      #14;
      rst = 1'b0;
      tick();
      chk("idle_state", 32'(bus.o_state), 32'd0);

      // Scenario 1/2: warm-up timing, then RUN samples 1,2,4,8 -> 0x3C.
      bus.i_en = 1'b1;
      warmup(4'h1);
      feed(4'h2);
      feed(4'h4);
      feed(4'h8);
      chk("w1_not_yet_valid", 32'(bus.o_valid), 32'd0);
      bus.i_ready = 1'b1;
      feed(4'h1);
      chk("w1_valid", 32'(bus.o_valid), 32'd1);
      chk("w1_rnd",   32'(bus.o_rnd),   32'h3C);

      // Transfer with no new word -> o_valid falls.
      feed(4'h2);
      chk("after_xfer_valid", 32'(bus.o_valid), 32'd0);

      // Scenario 3: ready low; 0x3C is held, 0x55 is dropped.
      bus.i_ready = 1'b0;
      feed(4'h4);
      feed(4'h8);
      feed(4'h1);
      chk("w2_valid", 32'(bus.o_valid), 32'd1);
      chk("w2_rnd",   32'(bus.o_rnd),   32'h3C);
      chk("w2_drop",  32'(bus.o_drop),  32'd0);
      feed(4'h4);
      feed(4'h2);
      feed(4'h7);
      feed(4'h8);
      chk("w3_drop",  32'(bus.o_drop),  32'd1);
      chk("w3_valid", 32'(bus.o_valid), 32'd1);
      chk("w3_rnd",   32'(bus.o_rnd),   32'h3C);
      feed(4'h1);
      chk("w3_drop_pulse_end", 32'(bus.o_drop), 32'd0);

      // Scenario 4: word 0x96 completes on the same edge as a transfer.
      feed(4'h4);
      feed(4'h2);
      chk("w4_pre_valid", 32'(bus.o_valid), 32'd1);
      chk("w4_pre_rnd",   32'(bus.o_rnd),   32'h3C);
      bus.i_ready = 1'b1;
      feed(4'h7);
      chk("w4_valid", 32'(bus.o_valid), 32'd1);
      chk("w4_rnd",   32'(bus.o_rnd),   32'h96);
      chk("w4_drop",  32'(bus.o_drop),  32'd0);

      // Scenario 5: raw stuck at 7; the 16th identical sample trips the alarm.
      bus.i_ready = 1'b0;
      for (int i = 0; i < 15; i++) feed(4'h7);
      chk("pre_alarm_state", 32'(bus.o_state), 32'd2);
      chk("pre_alarm_alarm", 32'(bus.o_alarm), 32'd0);
      chk("pre_alarm_valid", 32'(bus.o_valid), 32'd1);
      chk("pre_alarm_rnd",   32'(bus.o_rnd),   32'h96);
      feed(4'h7);
      chk("alarm_flag",  32'(bus.o_alarm),    32'd1);
      chk("alarm_ch",    32'(bus.o_alarm_ch), 32'd1);
      chk("alarm_state", 32'(bus.o_state),    32'd3);
      chk("alarm_valid", 32'(bus.o_valid),    32'd0);
      chk("alarm_rnd",   32'(bus.o_rnd),      32'h96);
      feed(4'h3);
      chk("alarm_hold_state", 32'(bus.o_state), 32'd3);
      chk("alarm_hold_flag",  32'(bus.o_alarm), 32'd1);
      bus.i_en = 1'b0;
      tick();
      chk("disable_state", 32'(bus.o_state),    32'd0);
      chk("disable_alarm", 32'(bus.o_alarm),    32'd0);
      chk("disable_ch",    32'(bus.o_alarm_ch), 32'd0);
      chk("disable_valid", 32'(bus.o_valid),    32'd0);

      // Scenario 6: restart, produce a word, then an asynchronous reset pulse.
      bus.i_en = 1'b1;
      warmup(4'h1);
      feed(4'h2);
      feed(4'h4);
      feed(4'h8);
      feed(4'h0);
      chk("w5_valid", 32'(bus.o_valid), 32'd1);
      chk("w5_rnd",   32'(bus.o_rnd),   32'h3C);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_reset");
      #3;
      rst = 1'b0;
      warmup(4'h5);
      chk("post_reset_rnd", 32'(bus.o_rnd), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
